// File: rtl/dispatch_pkg.sv
// Shared decoded-instruction layout for decoder, dispatch buffer and
// reservation stations.
//   INST_W      total decoded instruction width
//   *_MSB/_LSB  field bounds: rs2 val/tag | rs2_v | rs1 val/tag | rs1_v | rd | ctrl
//   ctrl is split into an ALU part (upper) and a dispatch-routing part (lower).
package dispatch_pkg;

  localparam int INST_W        = 83;

  localparam int RS2_VAL_MSB   = 82;
  localparam int RS2_VAL_LSB   = 51;
  localparam int RS2_V         = 50;
  localparam int RS1_VAL_MSB   = 49;
  localparam int RS1_VAL_LSB   = 18;
  localparam int RS1_V         = 17;
  localparam int RD_MSB        = 16;
  localparam int RD_LSB        = 12;
  localparam int CTRL_MSB      = 11;
  localparam int CTRL_LSB      = 0;
  localparam int ALU_CTRL_MSB  = 11;
  localparam int ALU_CTRL_LSB  = 4;
  localparam int DISP_CTRL_MSB = 3;
  localparam int DISP_CTRL_LSB = 0;

  localparam int CTRL_W        = CTRL_MSB - CTRL_LSB + 1;
  localparam int ALU_CTRL_W    = ALU_CTRL_MSB - ALU_CTRL_LSB + 1;
  localparam int DISP_CTRL_W   = DISP_CTRL_MSB - DISP_CTRL_LSB + 1;

  typedef struct packed {
    logic [31:0]            rs2_val;
    logic                   rs2_v;
    logic [31:0]            rs1_val;
    logic                   rs1_v;
    logic [4:0]             rd;
    logic [ALU_CTRL_W-1:0]  alu_ctrl;
    logic [DISP_CTRL_W-1:0] disp_ctrl;
  } decoded_inst_t;

endpackage

// File: rtl/dispatch_buffer_mem.sv
// Entry storage for the dispatch buffer: DEPTH x INST_W, two write ports and
// two asynchronous read ports. Entries clear on reset only.
// Ports:
//   clk, rst_n              clock / async active-low clear
//   we0/waddr0/wdata0       write port 0 (older of the pair)
//   we1/waddr1/wdata1       write port 1 (younger; address never equals waddr0)
//   raddr0/rdata0           read port 0
//   raddr1/rdata1           read port 1
module dispatch_buffer_mem #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 83,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [INST_W-1:0] wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [INST_W-1:0] wdata1,
  input  logic [AW-1:0]     raddr0,
  output logic [INST_W-1:0] rdata0,
  input  logic [AW-1:0]     raddr1,
  output logic [INST_W-1:0] rdata1
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/dispatch_buffer.sv
// Dual-issue in-order FIFO between decode/rename and dispatch. Takes up to two
// decoded instructions per cycle (A older than B), presents the two oldest
// entries to dispatch. A renamed-failed slot is dropped as a bubble so the
// Fetch/Decode FF holds and retries it.
// Optional build macro: DISPATCH_BUF_BYPASS_EN -- when empty, accepted inputs
// are forwarded straight to out_* and only the untaken ones are stored.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   flush                            discard all entries
//   in_valid*/decoded_inst*/error*   decode-side pair, A older
//   accept*                          slot written (or bypassed) this cycle
//   decode_stall                     fewer than 2 free entries
//   out_inst*/out_valid*/out_ready*  dispatch-side pair, A oldest
//   count                            occupancy 0..DEPTH
module dispatch_buffer #(
  parameter int DEPTH  = 8,
  parameter int INST_W = dispatch_pkg::INST_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_validA,
  input  logic                     in_validB,
  input  logic [INST_W-1:0]        decoded_instA,
  input  logic [INST_W-1:0]        decoded_instB,
  input  logic                     errorA,
  input  logic                     errorB,
  output logic                     acceptA,
  output logic                     acceptB,
  output logic                     decode_stall,
  output logic [INST_W-1:0]        out_instA,
  output logic                     out_validA,
  input  logic                     out_readyA,
  output logic [INST_W-1:0]        out_instB,
  output logic                     out_validB,
  input  logic                     out_readyB,
  output logic [$clog2(DEPTH):0]   count
);

  import dispatch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     free;
  logic              bypass;
  logic              deq_a, deq_b;
  logic              we0, we1;
  logic [INST_W-1:0] wdata0;
  logic [INST_W-1:0] rdata0, rdata1;
  logic              valid_a, valid_b;
  logic [INST_W-1:0] inst_a, inst_b;
  logic [1:0]        num_enq, num_deq, num_wr, num_rd;

  // Stall looks only at registered occupancy, so a full buffer stalls even
  // when dispatch drains it in the same cycle.
  assign free         = CW'(DEPTH) - count;
  assign decode_stall = (free < CW'(2));
  assign acceptA      = ~flush & ~decode_stall & in_validA & ~errorA;
  assign acceptB      = acceptA & in_validB & ~errorB;

`ifdef DISPATCH_BUF_BYPASS_EN
  assign bypass = (count == '0) & ~flush;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    valid_a = (count != '0);
    valid_b = (count > CW'(1));
    inst_a  = rdata0;
    inst_b  = rdata1;
    if (bypass) begin
      valid_a = acceptA;
      valid_b = acceptB;
      inst_a  = decoded_instA;
      inst_b  = decoded_instB;
    end
  end

  assign out_validA = valid_a;
  assign out_validB = valid_b;
  assign out_instA  = valid_a ? inst_a : '0;
  assign out_instB  = valid_b ? inst_b : '0;

  assign deq_a = out_validA & out_readyA;
  assign deq_b = deq_a & out_validB & out_readyB;

  // While bypassing, whatever dispatch takes is never stored; if A is taken
  // but B is not, B becomes the oldest stored entry at wr_ptr.
  always_comb begin
    we0    = acceptA;
    we1    = acceptB;
    wdata0 = decoded_instA;
    if (bypass && deq_a) begin
      we0    = acceptB & ~deq_b;
      we1    = 1'b0;
      wdata0 = decoded_instB;
    end
  end

  assign num_enq = {1'b0, acceptA} + {1'b0, acceptB};
  assign num_deq = {1'b0, deq_a} + {1'b0, deq_b};
  assign num_wr  = {1'b0, we0} + {1'b0, we1};
  assign num_rd  = bypass ? 2'd0 : num_deq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(num_rd);
      wr_ptr <= wr_ptr + AW'(num_wr);
      count  <= count + CW'(num_enq) - CW'(num_deq);
    end
  end

  dispatch_buffer_mem #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we0    (we0),
    .waddr0 (wr_ptr),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (wr_ptr + AW'(1)),
    .wdata1 (decoded_instB),
    .raddr0 (rd_ptr),
    .rdata0 (rdata0),
    .raddr1 (rd_ptr + AW'(1)),
    .rdata1 (rdata1)
  );

endmodule
